// File: rtl/nv_nvdla_mcif_write_eg_s_if.sv
// Bus bundle between the MCIF write egress block and its ingress/NOC/client neighbours.
interface nv_nvdla_mcif_write_eg_s_if;
    logic [31:0] pwrbus_ram_pd;
    logic        cq_wr_pvld;
    logic        cq_wr_prdy;
    logic [2:0]  cq_wr_thread_id;
    logic [2:0]  cq_wr_pd;
    logic        noc2mcif_axi_b_bvalid;
    logic        noc2mcif_axi_b_bready;
    logic [7:0]  noc2mcif_axi_b_bid;
    logic        eg2ig_axi_vld;
    logic [1:0]  eg2ig_axi_len;
    logic        mcif2sdp_wr_rsp_complete;
    logic        mcif2pdp_wr_rsp_complete;
    logic        mcif2cdp_wr_rsp_complete;

    modport slave (
        input  pwrbus_ram_pd,
        input  cq_wr_pvld,
        output cq_wr_prdy,
        input  cq_wr_thread_id,
        input  cq_wr_pd,
        input  noc2mcif_axi_b_bvalid,
        output noc2mcif_axi_b_bready,
        input  noc2mcif_axi_b_bid,
        output eg2ig_axi_vld,
        output eg2ig_axi_len,
        output mcif2sdp_wr_rsp_complete,
        output mcif2pdp_wr_rsp_complete,
        output mcif2cdp_wr_rsp_complete
    );

    modport master (
        output pwrbus_ram_pd,
        output cq_wr_pvld,
        input  cq_wr_prdy,
        output cq_wr_thread_id,
        output cq_wr_pd,
        output noc2mcif_axi_b_bvalid,
        input  noc2mcif_axi_b_bready,
        output noc2mcif_axi_b_bid,
        input  eg2ig_axi_vld,
        input  eg2ig_axi_len,
        input  mcif2sdp_wr_rsp_complete,
        input  mcif2pdp_wr_rsp_complete,
        input  mcif2cdp_wr_rsp_complete
    );
endinterface

// File: rtl/nv_nvdla_mcif_write_eg_s.sv
// MCIF write egress: per-thread completion-context FIFOs retired by AXI B responses,
// producing credit returns to ingress and per-client write-complete pulses.
module nv_nvdla_mcif_write_eg_s (
    input  logic                              nvdla_core_clk,
    input  logic                              nvdla_core_rstn,
    nv_nvdla_mcif_write_eg_s_if.slave         eg
);
    localparam int unsigned NUM_THR = 3;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PTR_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PD_W    = 3;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned IDX_W   = 2;

    logic [PD_W-1:0]  ctx_mem [NUM_THR][DEPTH];
    logic [CNT_W-1:0] occ     [NUM_THR];
    logic [PTR_W-1:0] wr_ptr  [NUM_THR];
    logic [PTR_W-1:0] rd_ptr  [NUM_THR];

    logic [NUM_THR-1:0] full;
    logic [NUM_THR-1:0] empty;
    logic [NUM_THR-1:0] push_en;
    logic [NUM_THR-1:0] pop_en;
    logic               push_id_ok;
    logic               pop_id_ok;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic [ID_W-1:0]    b_thr;
    logic               prdy_c;
    logic               bready_c;
    logic [PD_W-1:0]    pop_pd;
    logic               pop_any;

    // Power bus and upper id bits carry no function here.
    logic unused_inputs;
    assign unused_inputs = ^{eg.pwrbus_ram_pd, eg.noc2mcif_axi_b_bid[7:3]};

    // Thread decode, handshake readies and per-FIFO push/pop strobes.
    always_comb begin
        b_thr      = eg.noc2mcif_axi_b_bid[ID_W-1:0];
        push_id_ok = (eg.cq_wr_thread_id >= ID_W'(1)) && (eg.cq_wr_thread_id <= ID_W'(NUM_THR));
        pop_id_ok  = (b_thr >= ID_W'(1)) && (b_thr <= ID_W'(NUM_THR));
        push_idx   = IDX_W'(eg.cq_wr_thread_id - ID_W'(1));
        pop_idx    = IDX_W'(b_thr - ID_W'(1));
        full       = '0;
        empty      = '0;
        push_en    = '0;
        pop_en     = '0;
        pop_pd     = '0;
        for (int t = 0; t < NUM_THR; t++) begin
            full[t]  = (occ[t] == CNT_W'(DEPTH));
            empty[t] = (occ[t] == '0);
        end
        prdy_c   = push_id_ok ? ~full[push_idx]  : 1'b1;
        bready_c = pop_id_ok  ? ~empty[pop_idx]  : 1'b1;
        for (int t = 0; t < NUM_THR; t++) begin
            push_en[t] = eg.cq_wr_pvld && prdy_c && push_id_ok && (push_idx == IDX_W'(t));
            pop_en[t]  = eg.noc2mcif_axi_b_bvalid && bready_c && pop_id_ok && (pop_idx == IDX_W'(t));
            if (pop_idx == IDX_W'(t)) begin
                pop_pd = ctx_mem[t][rd_ptr[t]];
            end
        end
        pop_any = |pop_en;
    end

    assign eg.cq_wr_prdy            = prdy_c;
    assign eg.noc2mcif_axi_b_bready = bready_c;

    // Context storage; occupancy gates every read so no reset is needed.
    always_ff @(posedge nvdla_core_clk) begin
        for (int t = 0; t < NUM_THR; t++) begin
            if (push_en[t]) begin
                ctx_mem[t][wr_ptr[t]] <= eg.cq_wr_pd;
            end
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int t = 0; t < NUM_THR; t++) begin
                occ[t]    <= '0;
                wr_ptr[t] <= '0;
                rd_ptr[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THR; t++) begin
                if (push_en[t]) begin
                    wr_ptr[t] <= wr_ptr[t] + PTR_W'(1);
                end
                if (pop_en[t]) begin
                    rd_ptr[t] <= rd_ptr[t] + PTR_W'(1);
                end
                case ({push_en[t], pop_en[t]})
                    2'b10:   occ[t] <= occ[t] + CNT_W'(1);
                    2'b01:   occ[t] <= occ[t] - CNT_W'(1);
                    default: occ[t] <= occ[t];
                endcase
            end
        end
    end

    // Registered retirement outputs, one cycle after the B handshake.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            eg.eg2ig_axi_vld            <= 1'b0;
            eg.eg2ig_axi_len            <= '0;
            eg.mcif2sdp_wr_rsp_complete <= 1'b0;
            eg.mcif2pdp_wr_rsp_complete <= 1'b0;
            eg.mcif2cdp_wr_rsp_complete <= 1'b0;
        end else begin
            eg.eg2ig_axi_vld            <= pop_any;
            if (pop_any) begin
                eg.eg2ig_axi_len <= pop_pd[2:1];
            end
            eg.mcif2sdp_wr_rsp_complete <= pop_en[0] & pop_pd[0];
            eg.mcif2pdp_wr_rsp_complete <= pop_en[1] & pop_pd[0];
            eg.mcif2cdp_wr_rsp_complete <= pop_en[2] & pop_pd[0];
        end
    end
endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_s.sv
// Directed bench for the MCIF write egress block with hand-computed expectations.
module tb_nv_nvdla_mcif_write_eg_s;
    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_eg_s_if bus ();

    nv_nvdla_mcif_write_eg_s dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .eg              (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input logic [2:0] pd);
        bus.cq_wr_pvld      = 1'b1;
        bus.cq_wr_thread_id = id;
        bus.cq_wr_pd        = pd;
        step();
        bus.cq_wr_pvld      = 1'b0;
    endtask

    task automatic bresp(input logic [7:0] bid);
        bus.noc2mcif_axi_b_bvalid = 1'b1;
        bus.noc2mcif_axi_b_bid    = bid;
        step();
        bus.noc2mcif_axi_b_bvalid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [1:0] len,
                           input logic sdp, input logic pdp, input logic cdp);
        check({tag, "_vld"}, 32'(bus.eg2ig_axi_vld), 32'(vld));
        check({tag, "_len"}, 32'(bus.eg2ig_axi_len), 32'(len));
        check({tag, "_sdp"}, 32'(bus.mcif2sdp_wr_rsp_complete), 32'(sdp));
        check({tag, "_pdp"}, 32'(bus.mcif2pdp_wr_rsp_complete), 32'(pdp));
        check({tag, "_cdp"}, 32'(bus.mcif2cdp_wr_rsp_complete), 32'(cdp));
    endtask

    task automatic chk_prdy(input string tag, input logic [2:0] id, input logic exp);
        bus.cq_wr_thread_id = id;
        #1;
        check(tag, 32'(bus.cq_wr_prdy), 32'(exp));
    endtask

    task automatic chk_bready(input string tag, input logic [7:0] bid, input logic exp);
        bus.noc2mcif_axi_b_bid = bid;
        #1;
        check(tag, 32'(bus.noc2mcif_axi_b_bready), 32'(exp));
    endtask

    initial begin
        logic [2:0] v;
        rstn                      = 1'b0;
        bus.pwrbus_ram_pd         = 32'h0;
        bus.cq_wr_pvld            = 1'b0;
        bus.cq_wr_thread_id       = 3'd0;
        bus.cq_wr_pd              = 3'd0;
        bus.noc2mcif_axi_b_bvalid = 1'b0;
        bus.noc2mcif_axi_b_bid    = 8'h00;
        repeat (2) step();

        // Reset state
        chk_out("rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        step();
        chk_prdy("rst_prdy1", 3'd1, 1'b1);
        chk_prdy("rst_prdy3", 3'd3, 1'b1);
        chk_bready("rst_bready1", 8'h01, 1'b0);
        chk_bready("rst_bready2", 8'h02, 1'b0);

        // Basic path: thread 1, pd=101 -> len 2, SDP complete
        push(3'd1, 3'b101);
        chk_bready("basic_bready", 8'h01, 1'b1);
        bresp(8'h01);
        chk_out("basic", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("basic_idle", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        // Fill thread 3, then drain in order
        for (int i = 0; i < 8; i++) push(3'd3, 3'(i));
        chk_prdy("full_prdy3", 3'd3, 1'b0);
        chk_prdy("full_prdy1", 3'd1, 1'b1);
        chk_prdy("full_prdy2", 3'd2, 1'b1);
        bresp(8'h03);
        chk_out("full_pop0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk_prdy("full_prdy3_after", 3'd3, 1'b1);
        for (int i = 1; i < 8; i++) begin
            v = 3'(i);
            bresp(8'h03);
            chk_out($sformatf("drain%0d", i), 1'b1, v[2:1], 1'b0, 1'b0, v[0]);
        end
        chk_bready("drain_empty", 8'h03, 1'b0);

        // Wrap: 20 push/pop pairs through thread 3
        for (int i = 0; i < 20; i++) begin
            v = 3'(i % 8);
            push(3'd3, v);
            bresp(8'h03);
            chk_out($sformatf("wrap%0d", i), 1'b1, v[2:1], 1'b0, 1'b0, v[0]);
        end

        // Empty thread 2: no handshake, then no push-to-pop bypass
        bus.noc2mcif_axi_b_bvalid = 1'b1;
        bus.noc2mcif_axi_b_bid    = 8'h02;
        #1;
        check("empty_bready", 32'(bus.noc2mcif_axi_b_bready), 32'(1'b0));
        step();
        chk_out("empty_noout", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.cq_wr_pvld      = 1'b1;
        bus.cq_wr_thread_id = 3'd2;
        bus.cq_wr_pd        = 3'b011;
        #1;
        check("nobypass_bready", 32'(bus.noc2mcif_axi_b_bready), 32'(1'b0));
        step();
        bus.cq_wr_pvld = 1'b0;
        #1;
        check("push_next_bready", 32'(bus.noc2mcif_axi_b_bready), 32'(1'b1));
        step();
        bus.noc2mcif_axi_b_bvalid = 1'b0;
        chk_out("thr2_pop", 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);

        // Invalid ids
        bus.cq_wr_pvld      = 1'b1;
        bus.cq_wr_thread_id = 3'd5;
        bus.cq_wr_pd        = 3'b111;
        #1;
        check("inv_prdy", 32'(bus.cq_wr_prdy), 32'(1'b1));
        step();
        bus.cq_wr_pvld = 1'b0;
        chk_bready("inv_occ1", 8'h01, 1'b0);
        chk_bready("inv_occ2", 8'h02, 1'b0);
        chk_bready("inv_occ3", 8'h03, 1'b0);
        chk_bready("inv_bready", 8'hF6, 1'b1);
        bresp(8'hF6);
        chk_out("inv_b", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

        // Same-cycle push and pop on thread 1 holding one entry
        push(3'd1, 3'b010);
        bus.cq_wr_pvld            = 1'b1;
        bus.cq_wr_thread_id       = 3'd1;
        bus.cq_wr_pd              = 3'b111;
        bus.noc2mcif_axi_b_bvalid = 1'b1;
        bus.noc2mcif_axi_b_bid    = 8'h01;
        step();
        bus.cq_wr_pvld            = 1'b0;
        bus.noc2mcif_axi_b_bvalid = 1'b0;
        chk_out("conc_pop", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk_bready("conc_occ1", 8'h01, 1'b1);
        bresp(8'h01);
        chk_out("conc_pop2", 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        chk_bready("conc_empty", 8'h01, 1'b0);

        // Interleaved back-to-back responses 1,3,1
        push(3'd1, 3'b001);
        push(3'd3, 3'b111);
        push(3'd1, 3'b100);
        bus.noc2mcif_axi_b_bvalid = 1'b1;
        bus.noc2mcif_axi_b_bid    = 8'h01;
        step();
        chk_out("il_a", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.noc2mcif_axi_b_bid    = 8'h03;
        step();
        chk_out("il_b", 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        bus.noc2mcif_axi_b_bid    = 8'h01;
        step();
        bus.noc2mcif_axi_b_bvalid = 1'b0;
        chk_out("il_c", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("il_idle", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation with 5 entries in thread 2
        for (int i = 0; i < 5; i++) push(3'd2, 3'b101);
        bresp(8'h02);
        chk_out("pre_rst", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        rstn = 1'b1;
        step();
        chk_bready("post_rst_bready2", 8'h02, 1'b0);
        chk_prdy("post_rst_prdy2", 3'd2, 1'b1);
        chk_out("post_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nv_nvdla_mcif_write_eg_s.md
NV_NVDLA_MCIF_WRITE_EG_S -- requirements
Module: NV_NVDLA_MCIF_WRITE_eg_s

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: nvdla_core_clk and nvdla_core_rstn.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  async active-low reset
- pwrbus_ram_pd  in  32  RAM power-down bus; no functional effect
- cq_wr_pvld  in  1  completion-context push valid, from ingress
- cq_wr_prdy  out  1  completion-context push ready
- cq_wr_thread_id  in  3  context thread: 1=SDP, 2=PDP, 3=CDP
- cq_wr_pd  in  3  context: [0] require_ack, [2:1] axi_len (beats-1)
- noc2mcif_axi_b_bvalid  in  1  AXI write-response valid
- noc2mcif_axi_b_bready  out  1  AXI write-response ready
- noc2mcif_axi_b_bid  in  8  AXI response id; [2:0] selects the thread
- eg2ig_axi_vld  out  1  outstanding-credit return pulse to ingress
- eg2ig_axi_len  out  2  beats-1 of the retired request
- mcif2sdp_wr_rsp_complete  out  1  SDP write-complete pulse
- mcif2pdp_wr_rsp_complete  out  1  PDP write-complete pulse
- mcif2cdp_wr_rsp_complete  out  1  CDP write-complete pulse

Function
REQ-003 The block SHALL hold three independent context FIFOs, one per thread (1,2,3), each 8 entries x 3 bits, with a 4-bit occupancy counter and 3-bit wrapping read and write pointers.
REQ-004 cq_wr_prdy SHALL be ~full of the FIFO selected by cq_wr_thread_id when that id is 1..3, and SHALL be 1 for any other id.
REQ-005 A push SHALL occur on cq_wr_pvld & cq_wr_prdy. A valid id writes cq_wr_pd at the write pointer; ids 0 and 4..7 SHALL be accepted and discarded.
REQ-006 noc2mcif_axi_b_bready SHALL be combinational: ~empty of FIFO[bid[2:0]] for bid[2:0] in 1..3, and 1 otherwise. bid[7:3] SHALL be ignored.
REQ-007 A B handshake on a valid thread SHALL pop that FIFO head. A B handshake on an invalid thread SHALL pop nothing and produce no outputs.
REQ-008 Emptiness for REQ-006 SHALL come from the registered occupancy only. An entry pushed in cycle N SHALL be poppable no earlier than cycle N+1; there is no push-to-pop bypass.
REQ-009 A simultaneous push and pop on the same FIFO SHALL both occur; occupancy is unchanged and pointers advance independently.
REQ-010 A push while full SHALL be impossible (prdy=0). A pop while empty SHALL be impossible (bready=0).
REQ-011 Response latency SHALL be 1 cycle. In the cycle after a valid-thread B handshake:
- eg2ig_axi_vld=1 and eg2ig_axi_len=popped[2:1];
- if popped[0]=1, the matching mcif2<client>_wr_rsp_complete SHALL be 1.
All of these outputs SHALL be registered.
REQ-012 Otherwise eg2ig_axi_vld and all complete outputs SHALL be 0. eg2ig_axi_len SHALL hold its last value.
REQ-013 Back-to-back B handshakes SHALL produce back-to-back single-cycle pulses; a sustained rate of one response per cycle SHALL be supported.
REQ-014 Pointers SHALL wrap 7->0 with no lost or duplicated entry. Order within a thread SHALL be FIFO; threads SHALL be mutually independent.

Reset
REQ-015 Reset assertion SHALL asynchronously clear:
- all occupancy counters and pointers (FIFOs empty);
- eg2ig_axi_vld, eg2ig_axi_len and all complete outputs to 0.
FIFO storage SHALL need no reset.
REQ-016 Reset asserted mid-operation SHALL discard every stored context. After release, cq_wr_prdy=1 for all ids, and bready=0 for valid threads until a new push.

Verification
REQ-017 Basic path: push thread 1, pd=3'b101; next cycle B bid=8'h01 -> 1 cycle later eg2ig_axi_vld=1, eg2ig_axi_len=2'b10, mcif2sdp_wr_rsp_complete=1; other completes 0.
REQ-018 Full: push 8 entries to thread 3 -> cq_wr_prdy=0 for id 3 and 1 for ids 1/2. One B bid=3 -> prdy=1 the next cycle. Wrap check: 20 push/pop pairs with pd=i%8 return the same sequence.
REQ-019 Empty: B bid=2 with thread 2 empty -> bready=0, no output. Push thread 2 in cycle N -> bready=1 from cycle N+1.
REQ-020 Invalid ids: push id=5 -> accepted, no occupancy change. B bid=8'hF6 -> bready=1, no eg2ig_axi_vld, no complete.
REQ-021 Concurrency: thread 1 holding 1 entry receives a push and a pop in the same cycle -> occupancy stays 1. Interleaved B bid 1,3,1 -> pulses appear in that order, each with its own thread's len/ack.
REQ-022 Reset with 5 entries in thread 2 -> all outputs 0 immediately, thread 2 bready=0 after release.
